bpi_cmd_seq: RTL
================

BPI_CMD_SEQ -- requirements
Module: bpi_cmd_seq

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high: CLK input 1 (all logic on rising edge), RST input 1 (async, active-high).
REQ-002 SHALL have CMD_DATA input 16: command/argument word from a first-word-fall-through FIFO, valid while CMD_EMPTY=0.
REQ-003 SHALL have CMD_EMPTY input 1: FIFO empty flag.
REQ-004 SHALL have CMD_RE output 1: one-cycle pop strobe.
REQ-005 SHALL have EXECUTE output 1: one-cycle start pulse to the BPI interface FSM.
REQ-006 SHALL have READ and WRITE outputs, 1 bit each: operation select to the interface FSM.
REQ-007 SHALL have ADDR output 23 and WR_DATA output 16: flash word address and write data to the interface.
REQ-008 SHALL have IF_BUSY input 1, IF_LOAD input 1 and IF_RD_DATA input 16: interface busy flag, read-data strobe and read-data bus.
REQ-009 SHALL have RBK_DATA output 16 and RBK_WE output 1: readback word and its write strobe to the readback FIFO.
REQ-010 SHALL have SEQ_BUSY output 1 (command in progress) and ERR output 1 (one-cycle error pulse).

Function
REQ-011 SHALL decode the opcode from CMD_DATA[3:0]:
- 0 = NOP
- 1 = LOAD_ADDR: two argument words, the first supplying ADDR[22:16] from its bits [6:0], the second supplying ADDR[15:0].
- 2 = READ_N: N = CMD_DATA[15:4]; performs N+1 reads.
- 3 = WRITE_1: one argument word, the write data.
- 4 = UNLOCK: writes 0x0060, then 0x00D0.
- 5 = ERASE: writes 0x0020, then 0x00D0.
- 6 = READ_ARRAY: writes 0x00FF.
- 7-15 = illegal.
REQ-012 SHALL implement states IDLE, FETCH, DECODE, GET_ARG, ISSUE, ARM, WAIT_DONE and NEXT.
REQ-013 IDLE SHALL move to FETCH when CMD_EMPTY=0.
- FETCH SHALL latch CMD_DATA, pulse CMD_RE and go to DECODE.
- GET_ARG SHALL wait for CMD_EMPTY=0, then latch the word and pulse CMD_RE.
REQ-014 ISSUE SHALL assert EXECUTE for exactly one cycle, with READ or WRITE asserted in the same cycle.
REQ-015 READ or WRITE, ADDR and WR_DATA SHALL stay stable from ISSUE until WAIT_DONE exits.
REQ-016 ARM SHALL last one cycle with IF_BUSY ignored; WAIT_DONE SHALL exit on the first cycle IF_BUSY=0.
REQ-017 READ and WRITE SHALL never be asserted simultaneously.
REQ-018 Each IF_LOAD pulse SHALL register IF_RD_DATA into RBK_DATA and assert RBK_WE on the following cycle for one cycle.
REQ-019 READ_N SHALL increment ADDR by 1 after every completed read, wrapping from 0x7FFFFF to 0x000000.
- WRITE, UNLOCK, ERASE and READ_ARRAY SHALL leave ADDR unchanged.
REQ-020 The two-write sequences (UNLOCK, ERASE) SHALL issue their second transfer only after the first has returned to IF_BUSY=0.
REQ-021 An illegal opcode SHALL pulse ERR for one cycle, issue no flash access and return to IDLE.
REQ-022 SEQ_BUSY SHALL be 1 in every state except IDLE.
REQ-023 A partial LOAD_ADDR or WRITE_1 SHALL stall in GET_ARG while the FIFO is empty; ADDR SHALL NOT update until both argument words are received.
REQ-024 NOP SHALL consume one word and return to IDLE without pulsing EXECUTE.

Reset
REQ-025 RST SHALL force state IDLE and set to 0: CMD_RE, EXECUTE, READ, WRITE, ADDR, WR_DATA, RBK_DATA, RBK_WE, SEQ_BUSY, ERR and the read counter.
REQ-026 RST asserted mid-operation SHALL abandon the command; remaining FIFO words SHALL be decoded as fresh commands after release.

Configuration
REQ-027 Macro BPI_CMD_TIMEOUT_EN, when defined, SHALL add an 8-bit counter cleared on entry to WAIT_DONE.
- If IF_BUSY remains 1 for 255 WAIT_DONE cycles, the block SHALL pulse ERR, drop READ and WRITE, and return to IDLE, abandoning any remaining reads or writes of the command.
REQ-028 Without BPI_CMD_TIMEOUT_EN, WAIT_DONE SHALL wait indefinitely and no timeout logic SHALL exist.

Verification
REQ-029 Stimulus: LOAD_ADDR 0x0001, 0x0012, 0x3456, then READ_N 0x0032 (N=3), with a BFM model of the interface FSM (LOAD 5 cycles after EXECUTE).
- Required: 4 EXECUTE pulses with READ=1 at ADDR 0x123456..0x123459 and 4 RBK_WE pulses carrying the model data in order.
REQ-030 Stimulus: UNLOCK.
- Required: two WRITE transfers with WR_DATA 0x0060 then 0x00D0 at the same ADDR; the second EXECUTE only after IF_BUSY has fallen.
REQ-031 Stimulus: ADDR=0x7FFFFF, READ_N with N=1.
- Required: reads at 0x7FFFFF then 0x000000.
REQ-032 Stimulus: opcode 0x9.
- Required: ERR high for 1 cycle, no EXECUTE, SEQ_BUSY back to 0 within 3 cycles.
REQ-033 Stimulus: WRITE_1 with its data word delivered 20 cycles late.
- Required: block holds in GET_ARG, then one write of that data.
REQ-034 Stimulus: RST pulsed during WAIT_DONE of READ_N 0x0FF2, then (with BPI_CMD_TIMEOUT_EN) IF_BUSY held at 1.
- Required: after RST, all outputs are 0 and the next FIFO word is decoded as a command.
- Required: with IF_BUSY stuck at 1, ERR pulses after 255 cycles.

Source files
------------

// File: rtl/bpi_cmd_seq_if.sv
// Purpose : bundles the command-FIFO, flash-interface and readback signals of bpi_cmd_seq.
// Latency : none; this is wiring only.
// Backpressure: none here; the FIFO empty flag and interface busy flag stall the sequencer.
// Ports (master = sequencer side):
//   cmd_data/cmd_empty in, cmd_re out         : FWFT command FIFO
//   execute/read/write/addr/wr_data out       : request to the BPI interface FSM
//   if_busy/if_load/if_rd_data in             : interface status and read data
//   rbk_data/rbk_we out                       : readback FIFO write port
//   seq_busy/err out                          : sequencer status
interface bpi_cmd_seq_if;
  logic [15:0] cmd_data;
  logic        cmd_empty;
  logic        cmd_re;
  logic        execute;
  logic        read;
  logic        write;
  logic [22:0] addr;
  logic [15:0] wr_data;
  logic        if_busy;
  logic        if_load;
  logic [15:0] if_rd_data;
  logic [15:0] rbk_data;
  logic        rbk_we;
  logic        seq_busy;
  logic        err;

  modport master (
    input  cmd_data, cmd_empty, if_busy, if_load, if_rd_data,
    output cmd_re, execute, read, write, addr, wr_data, rbk_data, rbk_we, seq_busy, err
  );

  modport slave (
    output cmd_data, cmd_empty, if_busy, if_load, if_rd_data,
    input  cmd_re, execute, read, write, addr, wr_data, rbk_data, rbk_we, seq_busy, err
  );
endinterface

// File: rtl/bpi_cmd_seq.sv
// Purpose : decodes command words from a FWFT FIFO into BPI flash read/write transfers.
// Latency : FETCH->DECODE->ISSUE, so EXECUTE rises 3 cycles after a word is seen; readback 1 cycle after IF_LOAD.
// Backpressure: stalls in IDLE/GET_ARG while the FIFO is empty and in WAIT_DONE while IF_BUSY=1.
// Ports: clk, rst (async, active-high); bus = bpi_cmd_seq_if.master (see interface header).
// Option: define BPI_CMD_TIMEOUT_EN to abort a transfer whose IF_BUSY stays high for 255 WAIT_DONE cycles.
module bpi_cmd_seq (
  input  logic          clk,
  input  logic          rst,
  bpi_cmd_seq_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, GET_ARG, ISSUE, ARM, WAIT_DONE, NEXT} state_t;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_LOAD   = 4'd1;
  localparam logic [3:0] OP_READN  = 4'd2;
  localparam logic [3:0] OP_WRITE  = 4'd3;
  localparam logic [3:0] OP_UNLOCK = 4'd4;
  localparam logic [3:0] OP_ERASE  = 4'd5;
  localparam logic [3:0] OP_RDARR  = 4'd6;

  state_t      state_q, state_d;
  logic [15:0] cmd_q, cmd_d;
  logic        arg_idx_q, arg_idx_d;     // 0: expecting high address word, 1: low word
  logic [6:0]  addr_hi_q, addr_hi_d;     // staged so ADDR changes only when both words are in
  logic        second_q, second_d;       // 0x00D0 confirm write still owed
  logic [11:0] cnt_q, cnt_d;             // remaining reads after the current one
  logic [22:0] addr_q, addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [15:0] rbk_data_q, rbk_data_d;
  logic        read_q, read_d, write_q, write_d;
  logic        execute_q, execute_d, cmd_re_q, cmd_re_d;
  logic        rbk_we_q, rbk_we_d, seq_busy_q, seq_busy_d, err_q, err_d;
`ifdef BPI_CMD_TIMEOUT_EN
  logic [7:0]  to_cnt_q, to_cnt_d;
`endif

  logic [3:0] op;
  assign op = cmd_q[3:0];

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    arg_idx_d  = arg_idx_q;
    addr_hi_d  = addr_hi_q;
    second_d   = second_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    read_d     = read_q;
    write_d    = write_q;
    execute_d  = 1'b0;
    cmd_re_d   = 1'b0;
    err_d      = 1'b0;
    rbk_we_d   = bus.if_load;
    rbk_data_d = bus.if_load ? bus.if_rd_data : rbk_data_q;
`ifdef BPI_CMD_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif

    // cmd_re is registered, so the FIFO pops one cycle after the word is taken;
    // while cmd_re_q is high the FIFO head is stale and must not be consumed again.
    case (state_q)
      IDLE: begin
        if (!bus.cmd_empty && !cmd_re_q) begin
          cmd_re_d = 1'b1;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        cmd_d   = bus.cmd_data;
        state_d = DECODE;
      end
      DECODE: begin
        case (op)
          OP_NOP:   state_d = IDLE;
          OP_LOAD, OP_WRITE: begin
            arg_idx_d = 1'b0;
            state_d   = GET_ARG;
          end
          OP_READN: begin
            cnt_d     = cmd_q[15:4];
            read_d    = 1'b1;
            execute_d = 1'b1;
            state_d   = ISSUE;
          end
          OP_UNLOCK, OP_ERASE, OP_RDARR: begin
            wr_data_d = (op == OP_UNLOCK) ? 16'h0060 : (op == OP_ERASE) ? 16'h0020 : 16'h00FF;
            second_d  = (op != OP_RDARR);
            write_d   = 1'b1;
            execute_d = 1'b1;
            state_d   = ISSUE;
          end
          default: begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        endcase
      end
      GET_ARG: begin
        if (!bus.cmd_empty && !cmd_re_q) begin
          cmd_re_d = 1'b1;
          if (op == OP_WRITE) begin
            wr_data_d = bus.cmd_data;
            second_d  = 1'b0;
            write_d   = 1'b1;
            execute_d = 1'b1;
            state_d   = ISSUE;
          end else if (!arg_idx_q) begin
            addr_hi_d = bus.cmd_data[6:0];
            arg_idx_d = 1'b1;
          end else begin
            addr_d  = {addr_hi_q, bus.cmd_data};
            state_d = IDLE;
          end
        end
      end
      ISSUE: state_d = ARM;
      ARM: begin
`ifdef BPI_CMD_TIMEOUT_EN
        to_cnt_d = 8'd0;
`endif
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!bus.if_busy) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = NEXT;
        end
`ifdef BPI_CMD_TIMEOUT_EN
        else if (to_cnt_q == 8'd254) begin
          // 255th busy cycle: give up on the whole command
          err_d   = 1'b1;
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
`endif
      end
      NEXT: begin
        if (op == OP_READN) begin
          addr_d = addr_q + 23'd1;   // wraps naturally at 23 bits
          if (cnt_q == 12'd0) begin
            state_d = IDLE;
          end else begin
            cnt_d     = cnt_q - 12'd1;
            read_d    = 1'b1;
            execute_d = 1'b1;
            state_d   = ISSUE;
          end
        end else if (second_q) begin
          second_d  = 1'b0;
          wr_data_d = 16'h00D0;
          write_d   = 1'b1;
          execute_d = 1'b1;
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    seq_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      arg_idx_q  <= 1'b0;
      addr_hi_q  <= '0;
      second_q   <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      rbk_data_q <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      execute_q  <= 1'b0;
      cmd_re_q   <= 1'b0;
      rbk_we_q   <= 1'b0;
      seq_busy_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef BPI_CMD_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      arg_idx_q  <= arg_idx_d;
      addr_hi_q  <= addr_hi_d;
      second_q   <= second_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      rbk_data_q <= rbk_data_d;
      read_q     <= read_d;
      write_q    <= write_d;
      execute_q  <= execute_d;
      cmd_re_q   <= cmd_re_d;
      rbk_we_q   <= rbk_we_d;
      seq_busy_q <= seq_busy_d;
      err_q      <= err_d;
`ifdef BPI_CMD_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  assign bus.cmd_re   = cmd_re_q;
  assign bus.execute  = execute_q;
  assign bus.read     = read_q;
  assign bus.write    = write_q;
  assign bus.addr     = addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.rbk_data = rbk_data_q;
  assign bus.rbk_we   = rbk_we_q;
  assign bus.seq_busy = seq_busy_q;
  assign bus.err      = err_q;
endmodule
